// File: rtl/crxer_wb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crxer_wb_ctrl_pkg
//  Description : Shared widths, XER bit positions, requester IDs and helpers
//                for the CR/XER writeback controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package crxer_wb_ctrl_pkg;

    localparam int XER_WIDTH  = 32;
    localparam int CR_WIDTH   = 32;
    localparam int PEND_WIDTH = 3;
    localparam int N_REQ      = 3;

    // XER status bits, big-endian numbering
    localparam int XER_SO = 0;
    localparam int XER_OV = 1;
    localparam int XER_CA = 2;

    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        REQ_ALU = 2'd0,
        REQ_MDU = 2'd1,
        REQ_SPR = 2'd2
    } req_id_t;

    function automatic req_id_t next_req(input req_id_t id);
        case (id)
            REQ_ALU: return REQ_MDU;
            REQ_MDU: return REQ_SPR;
            default: return REQ_ALU;
        endcase
    endfunction

    // Slot k positions after ptr in the 3-entry ring
    function automatic logic [1:0] rr_slot(input logic [1:0] ptr, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, ptr} + {1'b0, k};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    // Returns {underflow, next_count}; inc and dec together cancel
    function automatic logic [PEND_WIDTH:0] pend_step(input logic [PEND_WIDTH-1:0] cnt,
                                                      input logic inc,
                                                      input logic dec);
        logic [PEND_WIDTH:0] res;
        res = {1'b0, cnt};
        if (inc && !dec) begin
            res = {1'b0, cnt + PEND_WIDTH'(1)};
        end else if (dec && !inc) begin
            if (cnt == '0) res = {1'b1, cnt};
            else           res = {1'b0, cnt - PEND_WIDTH'(1)};
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crxer_wb_ctrl_rr_arb3.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb3
//  Description : Three-way round-robin arbiter; pointer moves past the winner.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb3
    import crxer_wb_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_gnt,
    output logic             o_gnt_any
);

    req_id_t    r_ptr;
    logic [1:0] w_slot;
    logic [1:0] w_win;

    always_comb begin
        o_gnt     = '0;
        o_gnt_any = 1'b0;
        w_slot    = 2'd0;
        w_win     = 2'd0;
        if (!rst) begin
            for (int k = 0; k < N_REQ; k++) begin
                w_slot = rr_slot(r_ptr, 2'(k));
                if (!o_gnt_any && i_req[w_slot]) begin
                    o_gnt_any = 1'b1;
                    w_win     = w_slot;
                end
            end
            if (o_gnt_any) o_gnt[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= REQ_ALU;
        end else if (o_gnt_any) begin
            r_ptr <= next_req(req_id_t'(w_win));
        end
    end

endmodule
`default_nettype wire

// File: rtl/crxer_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : crxer_wb_ctrl
//  Description : CR/XER writeback arbiter with pending-write hazard tracking.
//                Optional macro CRXER_BYPASS_EN forwards commit data and
//                uses post-decrement counts for read hazards.
//  Revision    : 1.0 - initial release
// ============================================================================
module crxer_wb_ctrl
    import crxer_wb_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 alu_vld,
    input  logic                 alu_xer_we,
    input  logic                 alu_cr_we,
    input  logic [0:XER_WIDTH-1] alu_xerwd,
    input  logic [0:CR_WIDTH-1]  alu_crwd,
    output logic                 alu_rdy,

    input  logic                 mdu_vld,
    input  logic                 mdu_xer_we,
    input  logic                 mdu_cr_we,
    input  logic [0:XER_WIDTH-1] mdu_xerwd,
    input  logic [0:CR_WIDTH-1]  mdu_crwd,
    output logic                 mdu_rdy,

    input  logic                 spr_vld,
    input  logic                 spr_xer_we,
    input  logic                 spr_cr_we,
    input  logic [0:XER_WIDTH-1] spr_xerwd,
    input  logic [0:CR_WIDTH-1]  spr_crwd,
    output logic                 spr_rdy,

    input  logic                 iss_xer_wr,
    input  logic                 iss_cr_wr,
    input  logic                 iss_xer_rd,
    input  logic                 iss_cr_rd,

    output logic [0:XER_WIDTH-1] XERrd,
    output logic [0:CR_WIDTH-1]  CRrd,
    output logic                 stall,
    output logic                 pend_err
);

    logic [0:XER_WIDTH-1]  r_xer;
    logic [0:CR_WIDTH-1]   r_cr;
    logic [PEND_WIDTH-1:0] r_xer_pend;
    logic [PEND_WIDTH-1:0] r_cr_pend;
    logic                  r_pend_err;

    logic [N_REQ-1:0]      w_req;
    logic [N_REQ-1:0]      w_gnt;
    logic                  w_gnt_any;

    logic                  w_gnt_xer_we;
    logic                  w_gnt_cr_we;
    logic [0:XER_WIDTH-1]  w_gnt_xerwd;
    logic [0:CR_WIDTH-1]   w_gnt_crwd;

    logic                  w_xer_dec;
    logic                  w_cr_dec;
    logic                  w_xer_inc;
    logic                  w_cr_inc;
    logic [PEND_WIDTH-1:0] w_xer_pend_rd;
    logic [PEND_WIDTH-1:0] w_cr_pend_rd;
    logic [PEND_WIDTH:0]   w_xer_step;
    logic [PEND_WIDTH:0]   w_cr_step;

    assign w_req = {spr_vld, mdu_vld, alu_vld};

    rr_arb3 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (w_req),
        .o_gnt     (w_gnt),
        .o_gnt_any (w_gnt_any)
    );

    assign alu_rdy = w_gnt[REQ_ALU];
    assign mdu_rdy = w_gnt[REQ_MDU];
    assign spr_rdy = w_gnt[REQ_SPR];

    // Grant is one-hot, so a priority select is equivalent to an OR-mux
    always_comb begin
        w_gnt_xer_we = 1'b0;
        w_gnt_cr_we  = 1'b0;
        w_gnt_xerwd  = '0;
        w_gnt_crwd   = '0;
        if (w_gnt[REQ_ALU]) begin
            w_gnt_xer_we = alu_xer_we;
            w_gnt_cr_we  = alu_cr_we;
            w_gnt_xerwd  = alu_xerwd;
            w_gnt_crwd   = alu_crwd;
        end else if (w_gnt[REQ_MDU]) begin
            w_gnt_xer_we = mdu_xer_we;
            w_gnt_cr_we  = mdu_cr_we;
            w_gnt_xerwd  = mdu_xerwd;
            w_gnt_crwd   = mdu_crwd;
        end else if (w_gnt[REQ_SPR]) begin
            w_gnt_xer_we = spr_xer_we;
            w_gnt_cr_we  = spr_cr_we;
            w_gnt_xerwd  = spr_xerwd;
            w_gnt_crwd   = spr_crwd;
        end
    end

    assign w_xer_dec = w_gnt_any & w_gnt_xer_we;
    assign w_cr_dec  = w_gnt_any & w_gnt_cr_we;

`ifdef CRXER_BYPASS_EN
    assign XERrd = w_xer_dec ? w_gnt_xerwd : r_xer;
    assign CRrd  = w_cr_dec  ? w_gnt_crwd  : r_cr;
    assign w_xer_pend_rd = (w_xer_dec && r_xer_pend != '0) ? r_xer_pend - PEND_WIDTH'(1) : r_xer_pend;
    assign w_cr_pend_rd  = (w_cr_dec  && r_cr_pend  != '0) ? r_cr_pend  - PEND_WIDTH'(1) : r_cr_pend;
`else
    assign XERrd = r_xer;
    assign CRrd  = r_cr;
    assign w_xer_pend_rd = r_xer_pend;
    assign w_cr_pend_rd  = r_cr_pend;
`endif

    assign stall = !rst && ((iss_xer_rd && w_xer_pend_rd != '0) ||
                            (iss_cr_rd  && w_cr_pend_rd  != '0) ||
                            (iss_xer_wr && r_xer_pend == PEND_MAX) ||
                            (iss_cr_wr  && r_cr_pend  == PEND_MAX));

    // A stalled issue slot does not count as issued
    assign w_xer_inc = iss_xer_wr & ~stall;
    assign w_cr_inc  = iss_cr_wr  & ~stall;

    assign w_xer_step = pend_step(r_xer_pend, w_xer_inc, w_xer_dec);
    assign w_cr_step  = pend_step(r_cr_pend,  w_cr_inc,  w_cr_dec);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xer      <= '0;
            r_cr       <= '0;
            r_xer_pend <= '0;
            r_cr_pend  <= '0;
            r_pend_err <= 1'b0;
        end else begin
            if (w_xer_dec) r_xer <= w_gnt_xerwd;
            if (w_cr_dec)  r_cr  <= w_gnt_crwd;
            r_xer_pend <= w_xer_step[PEND_WIDTH-1:0];
            r_cr_pend  <= w_cr_step[PEND_WIDTH-1:0];
            r_pend_err <= r_pend_err | w_xer_step[PEND_WIDTH] | w_cr_step[PEND_WIDTH];
        end
    end

    assign pend_err = r_pend_err;

endmodule
`default_nettype wire
